// File: rtl/gnrc_stream_arb_pkg.sv
// Shared helpers for the round-robin stream arbiter.
package gnrc_stream_arb_pkg;

   // Modulo-N increment for the priority pointer; N need not be a power of two.
   function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/gnrc_rr_arbiter.sv
// Round-robin pick with grant lock: holds the granted requester while its beat is stalled.
module gnrc_rr_arbiter
   import gnrc_stream_arb_pkg::*;
#(
   parameter int unsigned N = 4,
   localparam int unsigned IW = $clog2(N)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [N-1:0]  req,
   input  logic          hold,
   input  logic          ack,
   input  logic          flush,
   output logic [IW-1:0] grant,
   output logic          grant_valid
);

   logic [IW-1:0] prio_q;
   logic [IW-1:0] lock_idx_q;
   logic          lock_q;
   logic [IW-1:0] pick;
   logic          found;
   int unsigned   k;

   // First valid requester at or above prio_q, wrapping at N.
   always_comb begin
      pick  = prio_q;
      found = 1'b0;
      k     = 0;
      for (int unsigned i = 0; i < N; i++) begin
         k = (32'(prio_q) + i) % N;
         if (!found && req[k]) begin
            pick  = IW'(k);
            found = 1'b1;
         end
      end
   end

   assign grant       = lock_q ? lock_idx_q : pick;
   assign grant_valid = req[grant];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         prio_q     <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
      end else begin
         lock_idx_q <= grant;
         if (flush) begin
            prio_q <= '0;
            lock_q <= 1'b0;
         end else begin
            lock_q <= hold;
            if (ack) prio_q <= IW'(rr_next(32'(grant), N));
         end
      end
   end

endmodule

// File: rtl/gnrc_slice.sv
// Ready/valid register slice; with both cuts on it is a 2-entry skid buffer.
module gnrc_slice #(
   parameter type T          = logic,
   parameter bit  FORWARD_Q  = 1'b1,
   parameter bit  BACKWARD_Q = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic flush_i,
   input  logic valid_i,
   output logic ready_o,
   input  T     data_i,
   output logic valid_o,
   input  logic ready_i,
   output T     data_o
);

   if (!FORWARD_Q) begin : g_pass
      assign valid_o = valid_i;
      assign data_o  = data_i;
      assign ready_o = ready_i;
   end else begin : g_reg
      logic out_vld, skid_vld, load;
      T     out_q, skid_q;

      assign load    = ready_i | ~out_vld;
      assign ready_o = BACKWARD_Q ? ~skid_vld : load;
      assign valid_o = out_vld;
      assign data_o  = out_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
            out_q    <= '0;
            skid_q   <= '0;
         end else if (flush_i) begin
            out_vld  <= 1'b0;
            skid_vld <= 1'b0;
         end else if (load) begin
            // ready_o is low while the skid entry is full, so no input is lost here.
            if (skid_vld) begin
               out_vld  <= 1'b1;
               out_q    <= skid_q;
               skid_vld <= 1'b0;
            end else begin
               out_vld <= valid_i;
               if (valid_i) out_q <= data_i;
            end
         end else if (BACKWARD_Q && valid_i && ready_o) begin
            skid_vld <= 1'b1;
            skid_q   <= data_i;
         end
      end
   end

endmodule

// File: rtl/gnrc_stream_arb.sv
// Round-robin stream arbiter: N ready/valid requesters onto one channel, tagged with the source index.
module gnrc_stream_arb #(
   parameter int unsigned N     = 4,
   parameter int unsigned DW    = 1,
   parameter type         DTYPE = logic [DW-1:0],
   parameter bit          OUT_Q = 1'b1,
   localparam int unsigned IW   = $clog2(N)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               flush_i,
   input  logic [N-1:0]       valid_i,
   input  DTYPE [N-1:0]       data_i,
   output logic [N-1:0]       ready_o,
   output logic               valid_o,
   output DTYPE               data_o,
   output logic [IW-1:0]      idx_o,
   input  logic               ready_i
);

   typedef struct packed {
      logic [IW-1:0] idx;
      DTYPE          data;
   } beat_t;

   logic [IW-1:0] grant;
   logic          core_valid, core_ready;
   beat_t         core_beat;

   gnrc_rr_arbiter #(.N(N)) u_arb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req         (valid_i),
      .hold        (core_valid & ~core_ready),
      .ack         (core_valid & core_ready),
      .flush       (flush_i),
      .grant       (grant),
      .grant_valid (core_valid)
   );

   assign core_beat.idx  = grant;
   assign core_beat.data = data_i[grant];

   // Reset gating keeps upstream from seeing a handshake whose beat would be discarded.
   for (genvar g = 0; g < N; g++) begin : g_rdy
      assign ready_o[g] = ~rst_i & core_ready & core_valid & (grant == IW'(g));
   end

   if (OUT_Q) begin : g_slice
      logic  rst_n;
      beat_t out_beat;

      assign rst_n = ~rst_i;

      gnrc_slice #(.T(beat_t), .FORWARD_Q(1'b1), .BACKWARD_Q(1'b1)) u_slice (
         .clk_i   (clk_i),
         .rst_ni  (rst_n),
         .flush_i (flush_i),
         .valid_i (core_valid),
         .ready_o (core_ready),
         .data_i  (core_beat),
         .valid_o (valid_o),
         .ready_i (ready_i),
         .data_o  (out_beat)
      );

      assign data_o = out_beat.data;
      assign idx_o  = out_beat.idx;
   end else begin : g_comb
      assign core_ready = ready_i;
      assign valid_o    = core_valid;
      assign data_o     = core_beat.data;
      assign idx_o      = core_beat.idx;
   end

endmodule

// File: tb/tb_gnrc_stream_arb.sv
// Bench for gnrc_stream_arb: registered and combinational variants driven from shared stimulus.
module tb_gnrc_stream_arb;
   localparam int N = 4;

   logic              clk = 1'b0;
   logic              rst_i, flush_i, ready_i;
   logic [N-1:0]      valid_i;
   logic [N-1:0][7:0] data_i;
   logic [N-1:0]      rdy1, rdy0;
   logic              vo1, vo0;
   logic [7:0]        do1, do0;
   logic [1:0]        io1, io0;

   always #5 clk = ~clk;

   gnrc_stream_arb #(.N(N), .DW(8), .DTYPE(logic [7:0]), .OUT_Q(1'b1)) dut_q (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .data_i(data_i),
      .ready_o(rdy1), .valid_o(vo1), .data_o(do1), .idx_o(io1), .ready_i(ready_i));

   gnrc_stream_arb #(.N(N), .DW(8), .DTYPE(logic [7:0]), .OUT_Q(1'b0)) dut_c (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .data_i(data_i),
      .ready_o(rdy0), .valid_o(vo0), .data_o(do0), .idx_o(io0), .ready_i(ready_i));

   int checks = 0, failures = 0;

   typedef struct {int idx; int data;} beat_t;
   beat_t exp_q[$];

   // Reference model: per-variant priority/lock, plus slice occupancy for the registered one.
   int prio[2], lockd[2], lidx[2];
   int occ;

   logic [N-1:0]      vin, last_hs;
   logic [N-1:0][7:0] din;
   logic              rdy, fl;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input int m);
      if (lockd[m] != 0) return lidx[m];
      for (int i = 0; i < N; i++)
         if (vin[(prio[m] + i) % N]) return (prio[m] + i) % N;
      return prio[m];
   endfunction

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         prio[m] = 0; lockd[m] = 0; lidx[m] = 0;
      end
      occ = 0;
      exp_q.delete();
   endtask

   task automatic step();
      int           g[2];
      logic         cv[2], cr[2];
      logic [N-1:0] er;
      valid_i = vin; data_i = din; ready_i = rdy; flush_i = fl;
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         g[m]  = pick(m);
         cv[m] = vin[g[m]];
         cr[m] = (m == 0) ? (occ < 2) : rdy;
      end
      er = '0; if (cv[0] && cr[0]) er[g[0]] = 1'b1;
      last_hs = er;
      chk("ready_o_reg", rdy1, er);
      er = '0; if (cv[1] && cr[1]) er[g[1]] = 1'b1;
      chk("ready_o_comb", rdy0, er);
      chk("valid_o_reg", vo1, occ > 0);
      chk("valid_o_comb", vo0, cv[1]);
      if (cv[1]) begin
         chk("idx_o_comb", io0, g[1]);
         chk("data_o_comb", do0, din[g[1]]);
      end
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         if (fl) begin
            prio[m] = 0; lockd[m] = 0;
         end else begin
            if (cv[m] && cr[m]) prio[m] = (g[m] + 1) % N;
            lockd[m] = (cv[m] && !cr[m]) ? 1 : 0;
            lidx[m]  = g[m];
         end
      end
      if (fl) begin
         occ = 0;
         exp_q.delete();
      end else begin
         if (occ > 0 && rdy) occ--;
         if (cv[0] && cr[0]) begin
            occ++;
            exp_q.push_back('{g[0], int'(din[g[0]])});
         end
      end
      #1;
   endtask

   // Output monitor for the registered variant: every accepted output beat must match the queue head.
   always @(negedge clk) begin
      beat_t b;
      if (rst_i === 1'b0 && vo1 === 1'b1 && ready_i === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_beat actual idx=%0d data=%0h expected none", io1, do1);
         end else begin
            b = exp_q.pop_front();
            chk("out_idx", io1, b.idx);
            chk("out_data", do1, b.data);
         end
      end
   end

   initial begin
      rst_i = 1'b1; vin = '0; din = '0; rdy = 1'b0; fl = 1'b0; last_hs = '0;
      valid_i = '0; data_i = '0; ready_i = 1'b0; flush_i = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b0;

      // Load beats, then reset in the middle of a cycle.
      vin = 4'hF;
      for (int k = 0; k < N; k++) din[k] = 8'(8'h10 + k);
      rdy = 1'b0;
      repeat (3) step();
      #2 rst_i = 1'b1;
      #1;
      chk("rst_valid_o", vo1, 0);
      chk("rst_idx_o", io1, 0);
      chk("rst_data_o", do1, 0);
      chk("rst_ready_o", rdy1, 0);
      model_reset();
      vin = '0;
      @(posedge clk);
      #1 rst_i = 1'b0;

      // Single request after reset.
      vin = 4'b0100; din[2] = 8'h5A; rdy = 1'b1;
      step();
      vin = '0;
      repeat (3) step();

      // Full round robin from a cleared pointer.
      fl = 1'b1; step(); fl = 1'b0;
      vin = 4'hF;
      for (int k = 0; k < N; k++) din[k] = 8'(8'h10 + k);
      repeat (9) step();

      // Backpressure with a late competing request.
      fl = 1'b1; vin = '0; step(); fl = 1'b0;
      vin = 4'b0010; rdy = 1'b0;
      step(); step();
      vin = 4'b0011; step();
      rdy = 1'b1;
      repeat (4) step();
      vin = '0; step();

      // Wrap and skip.
      fl = 1'b1; step(); fl = 1'b0;
      vin = 4'b0100; step();
      vin = 4'b0010; step();
      vin = '0; repeat (3) step();

      // Flush with a full slice.
      vin = 4'hF; rdy = 1'b0;
      repeat (4) step();
      fl = 1'b1; step(); fl = 1'b0;
      rdy = 1'b1;
      repeat (5) step();

      // Locked requester drops valid under backpressure.
      fl = 1'b1; vin = '0; step(); fl = 1'b0;
      vin = 4'b1000; rdy = 1'b0;
      repeat (4) step();
      vin = 4'b0001; repeat (3) step();
      rdy = 1'b1; repeat (4) step();
      vin = '0; step();

      // Randomized traffic with occasional protocol violations and flushes.
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < N; k++) begin
            if (vin[k] && last_hs[k]) begin
               vin[k] = ($urandom_range(0, 3) != 0);
               din[k] = 8'($urandom);
            end else if (!vin[k]) begin
               vin[k] = ($urandom_range(0, 9) < 4);
               din[k] = 8'($urandom);
            end else if ($urandom_range(0, 31) == 0) begin
               vin[k] = 1'b0;
            end
         end
         rdy = ($urandom_range(0, 3) != 0);
         fl  = ($urandom_range(0, 99) == 0);
         step();
      end

      vin = '0; fl = 1'b0; rdy = 1'b1;
      repeat (5) step();
      chk("drain_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
